inst_sram_like_responder: RTL and testbench

- Responder (slave) end of the sram-like request/response protocol that the fetch stage drives as initiator.
- Accepts address phases (req/addr_ok), performs the access on a one-cycle-latency synchronous word memory, and returns data phases (data_ok/rdata) strictly in order.
- Used as the instruction/data memory model in core-level simulation and as the front end of on-chip boot memory.
- Every accepted request, read or write, produces exactly one data_ok, so the initiator can count and discard responses.

---
 rtl/inst_sram_like_responder_pkg.sv | 15 +
 rtl/sram_like_resp_fifo.sv | 112 +++++++++++
 rtl/inst_sram_like_responder.sv | 93 +++++++++
 tb/tb_inst_sram_like_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_sram_like_responder_pkg.sv
// Shared definitions for the sram-like responder: transfer size codes and
// the per-response bookkeeping entry held in the response FIFO.
package inst_sram_like_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic        wr;
    logic        pend;
    logic [31:0] data;
  } resp_entry_t;

endpackage

// File: rtl/sram_like_resp_fifo.sv
// In-order response queue: each entry waits for its countdown to expire and,
// for reads, for the memory word captured one cycle after its accept.
module sram_like_resp_fifo
  import inst_sram_like_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned LATENCY = 1,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             push_wr_i,
  input  logic             capture_i,
  input  logic [31:0]      capture_data_i,
  input  logic             pop_i,
  output logic             head_ready_o,
  output logic             head_wr_o,
  output logic [31:0]      head_data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CD_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CD_W-1:0] CD_INIT = CD_W'(LATENCY - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CD_W-1:0]  cd_q [DEPTH];
  logic [CD_W-1:0]  cd_d [DEPTH];
  resp_entry_t      ent_q [DEPTH];
  resp_entry_t      ent_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] last_ptr_q, last_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cap_hit;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // A read's data arrives in the same cycle it may become due, so the
  // capture is forwarded straight to the head when they coincide.
  assign cap_hit      = capture_i && (last_ptr_q == rd_ptr_q);
  assign head_ready_o = valid_q[rd_ptr_q] && (cd_q[rd_ptr_q] == '0) &&
                        (!ent_q[rd_ptr_q].pend || cap_hit);
  assign head_wr_o    = ent_q[rd_ptr_q].wr;
  assign head_data_o  = cap_hit ? capture_data_i : ent_q[rd_ptr_q].data;
  assign count_o      = count_q;

  always_comb begin
    valid_d    = valid_q;
    cd_d       = cd_q;
    ent_d      = ent_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    last_ptr_d = last_ptr_q;
    count_d    = count_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (cd_q[i] != '0)) cd_d[i] = cd_q[i] - 1'b1;
    end

    if (capture_i) begin
      ent_d[last_ptr_q].pend = 1'b0;
      ent_d[last_ptr_q].data = capture_data_i;
    end

    if (pop_i) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = ptr_next(rd_ptr_q);
    end

    if (push_i) begin
      valid_d[wr_ptr_q] = 1'b1;
      cd_d[wr_ptr_q]    = CD_INIT;
      ent_d[wr_ptr_q]   = '{wr: push_wr_i, pend: !push_wr_i, data: 32'h0};
      last_ptr_d        = wr_ptr_q;
      wr_ptr_d          = ptr_next(wr_ptr_q);
    end

    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      last_ptr_q <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        cd_q[i]  <= '0;
        ent_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      last_ptr_q <= last_ptr_d;
      count_q    <= count_d;
      cd_q       <= cd_d;
      ent_q      <= ent_d;
    end
  end

endmodule

// File: rtl/inst_sram_like_responder.sv
// Responder end of the sram-like protocol: accepts address phases, drives a
// one-cycle-latency word memory and returns one in-order data phase per accept.
module inst_sram_like_responder #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned MEM_AW  = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              wr_i,
  input  logic [1:0]        size_i,
  input  logic [3:0]        wstrb_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              addr_ok_o,
  output logic              data_ok_o,
  output logic [31:0]       rdata_o,
  input  logic              hold_i,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  import inst_sram_like_responder_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  logic             accept;
  logic [3:0]       size_mask;
  logic [3:0]       byte_mask;
  logic             cap_q, cap_d;
  logic             head_ready;
  logic             head_wr;
  logic [31:0]      head_data;
  logic [CNT_W-1:0] count;
  logic             unused_addr;

  // Reset gating keeps the combinational handshake quiet while rst_i is high.
  assign accept = req_i && !hold_i && (count < FULL_C) && !rst_i;

  always_comb begin
    size_mask = 4'b1111;
    case (size_i)
      SIZE_BYTE: size_mask = 4'b0001 << addr_i[1:0];
      SIZE_HALF: size_mask = addr_i[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: size_mask = 4'b1111;
      default:   size_mask = 4'b1111;
    endcase
    byte_mask = size_mask & wstrb_i;
  end

  assign addr_ok_o   = accept;
  assign mem_en_o    = accept;
  assign mem_we_o    = (accept && wr_i) ? byte_mask : 4'b0000;
  assign mem_addr_o  = addr_i[MEM_AW+1:2];
  assign mem_wdata_o = wdata_i;

  // The memory answers one cycle after the enable; remember that a read
  // result is due so the FIFO can capture it into the last-pushed entry.
  assign cap_d = accept && !wr_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cap_q <= 1'b0;
    else       cap_q <= cap_d;
  end

  sram_like_resp_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_fifo (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .push_i         (accept),
    .push_wr_i      (wr_i),
    .capture_i      (cap_q),
    .capture_data_i (mem_rdata_i),
    .pop_i          (head_ready),
    .head_ready_o   (head_ready),
    .head_wr_o      (head_wr),
    .head_data_o    (head_data),
    .count_o        (count)
  );

  assign data_ok_o = head_ready;
  assign rdata_o   = (head_ready && !head_wr) ? head_data : 32'h0;

  assign unused_addr = ^addr_i[31:MEM_AW+2];

endmodule

// File: tb/tb_inst_sram_like_responder.sv
// Directed bench: a LATENCY=1 instance for reads/writes/masks/hold and a
// LATENCY=4 instance for back-pressure and asynchronous reset.
module tb_inst_sram_like_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // instance a: DEPTH=2, LATENCY=1
  logic        a_req, a_wr, a_hold;
  logic [1:0]  a_size;
  logic [3:0]  a_wstrb;
  logic [31:0] a_addr, a_wdata;
  logic        a_addr_ok, a_data_ok, a_mem_en;
  logic [31:0] a_rdata, a_mem_wdata;
  logic [31:0] a_mem_rdata = 32'h0;
  logic [3:0]  a_mem_we;
  logic [13:0] a_mem_addr;
  logic [31:0] amem [0:16383];

  // instance b: DEPTH=2, LATENCY=4
  logic        b_req, b_wr, b_hold;
  logic [1:0]  b_size;
  logic [3:0]  b_wstrb;
  logic [31:0] b_addr, b_wdata;
  logic        b_addr_ok, b_data_ok, b_mem_en;
  logic [31:0] b_rdata, b_mem_wdata;
  logic [31:0] b_mem_rdata = 32'h0;
  logic [3:0]  b_mem_we;
  logic [13:0] b_mem_addr;
  logic [31:0] bmem [0:16383];

  inst_sram_like_responder #(.DEPTH(2), .LATENCY(1), .MEM_AW(14)) u_a (
    .clk_i(clk), .rst_i(rst), .req_i(a_req), .wr_i(a_wr), .size_i(a_size),
    .wstrb_i(a_wstrb), .addr_i(a_addr), .wdata_i(a_wdata),
    .addr_ok_o(a_addr_ok), .data_ok_o(a_data_ok), .rdata_o(a_rdata),
    .hold_i(a_hold), .mem_en_o(a_mem_en), .mem_we_o(a_mem_we),
    .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata)
  );

  inst_sram_like_responder #(.DEPTH(2), .LATENCY(4), .MEM_AW(14)) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(b_req), .wr_i(b_wr), .size_i(b_size),
    .wstrb_i(b_wstrb), .addr_i(b_addr), .wdata_i(b_wdata),
    .addr_ok_o(b_addr_ok), .data_ok_o(b_data_ok), .rdata_o(b_rdata),
    .hold_i(b_hold), .mem_en_o(b_mem_en), .mem_we_o(b_mem_we),
    .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
  );

  // one-cycle-latency synchronous word memories with byte write enables
  always @(posedge clk) begin
    if (a_mem_en) begin
      a_mem_rdata <= amem[a_mem_addr];
      for (int i = 0; i < 4; i++)
        if (a_mem_we[i]) amem[a_mem_addr][8*i +: 8] <= a_mem_wdata[8*i +: 8];
    end
    if (b_mem_en) begin
      b_mem_rdata <= bmem[b_mem_addr];
      for (int j = 0; j < 4; j++)
        if (b_mem_we[j]) bmem[b_mem_addr][8*j +: 8] <= b_mem_wdata[8*j +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic req, input logic wr, input logic [1:0] size,
                         input logic [3:0] wstrb, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic hold);
    a_req = req; a_wr = wr; a_size = size; a_wstrb = wstrb;
    a_addr = addr; a_wdata = wdata; a_hold = hold;
  endtask

  task automatic drive_b(input logic req, input logic [31:0] addr);
    b_req = req; b_wr = 1'b0; b_size = 2'd2; b_wstrb = 4'h0;
    b_addr = addr; b_wdata = 32'h0; b_hold = 1'b0;
  endtask

  // inputs change just after the rising edge, outputs are sampled on the falling edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  mt_size  [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd1};
  logic [1:0]  mt_lo    [7] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2};
  logic [3:0]  mt_strb  [7] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'b1010, 4'b0111};
  logic [3:0]  mt_exp   [7] = '{4'b0001, 4'b0100, 4'b0011, 4'b1100, 4'b1111, 4'b1010, 4'b0100};

  logic        fl_aok [10] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0};
  logic        fl_dok [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1};
  logic [31:0] fl_rd  [10] = '{0, 0, 0, 0, 32'h2402_0001, 32'hCAFE_F00D, 0, 0, 0, 32'h0BAD_BEEF};

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    amem[5]    = 32'h2402_0001;
    amem[32'h40] = 32'h1122_3344;
    bmem[5]    = 32'h2402_0001;
    bmem[6]    = 32'hCAFE_F00D;
    bmem[7]    = 32'h0BAD_BEEF;
    drive_a(1'b1, 1'b1, 2'd2, 4'hF, 32'h14, 32'h0, 1'b0);
    drive_b(1'b1, 32'h14);

    // reset state with req asserted
    #3;
    check("rst_addr_ok", 32'(a_addr_ok), 32'h0);
    check("rst_data_ok", 32'(a_data_ok), 32'h0);
    check("rst_rdata",   a_rdata,        32'h0);
    check("rst_mem_en",  32'(a_mem_en),  32'h0);
    check("rst_mem_we",  32'(a_mem_we),  32'h0);
    check("rst_b_addr_ok", 32'(b_addr_ok), 32'h0);
    @(negedge clk);
    drive_a(1'b0, 1'b0, 2'd2, 4'h0, 32'h0, 32'h0, 1'b0);
    drive_b(1'b0, 32'h0);
    #2 rst = 1'b0;

    // single read, LATENCY=1
    next_cycle(); drive_a(1'b1, 1'b0, 2'd2, 4'h0, 32'h14, 32'h0, 1'b0);
    @(negedge clk);
    check("rd_addr_ok",  32'(a_addr_ok),  32'h1);
    check("rd_mem_en",   32'(a_mem_en),   32'h1);
    check("rd_mem_addr", 32'(a_mem_addr), 32'h5);
    check("rd_mem_we",   32'(a_mem_we),   32'h0);
    check("rd_data_ok0", 32'(a_data_ok),  32'h0);
    next_cycle(); drive_a(1'b0, 1'b0, 2'd2, 4'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("rd_data_ok1", 32'(a_data_ok), 32'h1);
    check("rd_rdata",    a_rdata,        32'h2402_0001);
    next_cycle(); @(negedge clk);
    check("rd_data_ok2", 32'(a_data_ok), 32'h0);
    check("rd_count",    32'(u_a.u_fifo.count_q), 32'h0);

    // byte write, read-back, half write, read-back (back-to-back)
    next_cycle(); drive_a(1'b1, 1'b1, 2'd0, 4'hF, 32'h103, 32'hAABB_CCDD, 1'b0);
    @(negedge clk);
    check("bw_addr_ok",  32'(a_addr_ok),  32'h1);
    check("bw_mem_we",   32'(a_mem_we),   32'h8);
    check("bw_mem_addr", 32'(a_mem_addr), 32'h40);
    check("bw_mem_wdata", a_mem_wdata,    32'hAABB_CCDD);
    next_cycle(); drive_a(1'b1, 1'b0, 2'd2, 4'h0, 32'h100, 32'h0, 1'b0);
    @(negedge clk);
    check("bw_resp_ok",    32'(a_data_ok), 32'h1);
    check("bw_resp_rdata", a_rdata,        32'h0);
    check("br_addr_ok",    32'(a_addr_ok), 32'h1);
    next_cycle(); drive_a(1'b1, 1'b1, 2'd1, 4'b0100, 32'h102, 32'h5566_7788, 1'b0);
    @(negedge clk);
    check("br_data_ok",  32'(a_data_ok), 32'h1);
    check("br_top_byte", 32'(a_rdata[31:24]), 32'hAA);
    check("br_rdata",    a_rdata,        32'hAA22_3344);
    check("hw_mem_we",   32'(a_mem_we),  32'h4);
    next_cycle(); drive_a(1'b1, 1'b0, 2'd2, 4'h0, 32'h100, 32'h0, 1'b0);
    @(negedge clk);
    check("hw_resp_ok",    32'(a_data_ok), 32'h1);
    check("hw_resp_rdata", a_rdata,        32'h0);
    next_cycle(); drive_a(1'b0, 1'b0, 2'd2, 4'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("hr_data_ok", 32'(a_data_ok), 32'h1);
    check("hr_rdata",   a_rdata,        32'hAA66_3344);
    next_cycle(); @(negedge clk);
    check("hr_idle", 32'(a_data_ok), 32'h0);

    // byte-mask table, one write per cycle
    for (int k = 0; k < 7; k++) begin
      next_cycle();
      drive_a(1'b1, 1'b1, mt_size[k], mt_strb[k], {30'h80, mt_lo[k]}, 32'h0, 1'b0);
      @(negedge clk);
      check($sformatf("mask_we_%0d", k), 32'(a_mem_we), 32'(mt_exp[k]));
      if (k > 0) check($sformatf("mask_ok_%0d", k), 32'(a_data_ok), 32'h1);
    end
    next_cycle(); drive_a(1'b0, 1'b0, 2'd2, 4'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("mask_last_ok",    32'(a_data_ok), 32'h1);
    check("mask_last_rdata", a_rdata,        32'h0);
    next_cycle(); @(negedge clk);
    check("mask_idle", 32'(a_data_ok), 32'h0);

    // hold for three cycles with req high
    for (int k = 0; k < 3; k++) begin
      next_cycle(); drive_a(1'b1, 1'b0, 2'd2, 4'h0, 32'h14, 32'h0, 1'b1);
      @(negedge clk);
      check($sformatf("hold_aok_%0d", k), 32'(a_addr_ok), 32'h0);
      check($sformatf("hold_en_%0d", k),  32'(a_mem_en),  32'h0);
      check($sformatf("hold_dok_%0d", k), 32'(a_data_ok), 32'h0);
    end
    next_cycle(); drive_a(1'b1, 1'b0, 2'd2, 4'h0, 32'h14, 32'h0, 1'b0);
    @(negedge clk);
    check("hold_release_aok", 32'(a_addr_ok), 32'h1);
    next_cycle(); drive_a(1'b0, 1'b0, 2'd2, 4'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("hold_dok",   32'(a_data_ok), 32'h1);
    check("hold_rdata", a_rdata,        32'h2402_0001);
    next_cycle(); @(negedge clk);
    check("hold_idle", 32'(a_data_ok), 32'h0);

    // fill / back-pressure on the LATENCY=4 instance
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      drive_b(c < 6, (c == 0) ? 32'h14 : (c == 1) ? 32'h18 : 32'h1C);
      @(negedge clk);
      check($sformatf("fill_aok_c%0d", c), 32'(b_addr_ok), 32'(fl_aok[c]));
      check($sformatf("fill_dok_c%0d", c), 32'(b_data_ok), 32'(fl_dok[c]));
      if (fl_dok[c]) check($sformatf("fill_rdata_c%0d", c), b_rdata, fl_rd[c]);
    end
    next_cycle(); drive_b(1'b0, 32'h0);
    @(negedge clk);
    check("fill_count", 32'(u_b.u_fifo.count_q), 32'h0);

    // asynchronous reset with two reads outstanding
    next_cycle(); drive_b(1'b1, 32'h14); @(negedge clk);
    check("ar_aok0", 32'(b_addr_ok), 32'h1);
    next_cycle(); drive_b(1'b1, 32'h18); @(negedge clk);
    check("ar_aok1", 32'(b_addr_ok), 32'h1);
    next_cycle(); drive_b(1'b1, 32'h1C); @(negedge clk);
    check("ar_full_aok",   32'(b_addr_ok), 32'h0);
    check("ar_full_count", 32'(u_b.u_fifo.count_q), 32'h2);
    #2 rst = 1'b1;
    #1;
    check("ar_in_aok",   32'(b_addr_ok), 32'h0);
    check("ar_in_dok",   32'(b_data_ok), 32'h0);
    check("ar_in_count", 32'(u_b.u_fifo.count_q), 32'h0);
    check("ar_in_mem_en", 32'(b_mem_en), 32'h0);
    drive_b(1'b0, 32'h0);
    #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      next_cycle(); @(negedge clk);
      check($sformatf("ar_stale_%0d", k), 32'(b_data_ok), 32'h0);
    end
    next_cycle(); drive_b(1'b1, 32'h18); @(negedge clk);
    check("ar_new_aok", 32'(b_addr_ok), 32'h1);
    for (int k = 1; k < 4; k++) begin
      next_cycle(); drive_b(1'b0, 32'h0); @(negedge clk);
      check($sformatf("ar_wait_%0d", k), 32'(b_data_ok), 32'h0);
    end
    next_cycle(); @(negedge clk);
    check("ar_new_dok",   32'(b_data_ok), 32'h1);
    check("ar_new_rdata", b_rdata,        32'hCAFE_F00D);
    next_cycle(); @(negedge clk);
    check("ar_new_idle", 32'(b_data_ok), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
